// File: rtl/bus_master_pkg.sv
// Shared definitions for the on-chip slave bus initiator: state encoding,
// bus polarity constants, default timeout and the slave-select map.
package bus_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } bm_state_e;

    // Bus direction on rw / req_rw
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Active-low strobe levels for cs_ / as_ / rdy_
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int DEFAULT_TIMEOUT = 16;

    // Slave-select map: value of the top SEL_W word-address bits
    localparam int SEL_MEM   = 0;
    localparam int SEL_ROM   = 1;
    localparam int SEL_TIMER = 2;
    localparam int SEL_UART  = 3;
    localparam int SEL_GPIO  = 4;

endpackage

// File: rtl/bus_master_if_cs_decoder.sv
// Combinational select decoder: SEL_W address bits to one-hot active-low
// chip selects. The caller registers the result.
module bus_cs_decoder
    import bus_master_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      sel_i,
    output logic [(2**SEL_W)-1:0] cs_n_o
);

    for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_cs
        assign cs_n_o[gi] = (sel_i == SEL_W'(gi)) ? ENABLE_ : DISABLE_;
    end

endmodule

// File: rtl/bus_master_if.sv
// Bus initiator: turns a held CPU request into one cs_/as_ bus cycle, waits
// for rdy_ (or a cycle budget) and returns a single ack with read data.
module bus_master_if
    import bus_master_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     req_rw,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wr_data,
    output logic                     ack,
    output logic                     err,
    output logic [DATA_W-1:0]        rd_data_out,
    output logic                     busy,
    output logic [(2**SEL_W)-1:0]    cs_,
    output logic                     as_,
    output logic                     rw,
    output logic [1:0]               addr,
    output logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W-1:0]        rd_data,
    input  logic                     rdy_
);

    localparam int NUM_CS = 2**SEL_W;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    bm_state_e            state_q;
    logic [NUM_CS-1:0]    cs_q;
    logic                 as_q;
    logic                 rw_q;
    logic [1:0]           addr_q;
    logic [DATA_W-1:0]    wr_data_q;
    logic                 ack_q;
    logic                 err_q;
    logic [DATA_W-1:0]    rd_data_q;
    logic                 busy_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [NUM_CS-1:0]    cs_d;
    logic [CNT_W-1:0]     cnt_d;
    logic                 timeout_hit;

    // Middle address bits are decoded by the slaves, not by the master.
    logic                 unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[ADDR_W-SEL_W-1:2]};

    bus_cs_decoder #(
        .SEL_W (SEL_W)
    ) u_cs_decoder (
        .sel_i  (req_addr[ADDR_W-1 -: SEL_W]),
        .cs_n_o (cs_d)
    );

    // Wait counter saturates so a disabled timeout can never alias back to zero.
    assign cnt_d       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cs_q      <= {NUM_CS{DISABLE_}};
            as_q      <= DISABLE_;
            rw_q      <= READ;
            addr_q    <= '0;
            wr_data_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (req) begin
                        rw_q      <= req_rw;
                        addr_q    <= req_addr[1:0];
                        wr_data_q <= req_wr_data;
                        cs_q      <= cs_d;
                        as_q      <= ENABLE_;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ACCESS;
                    end
                end

                ACCESS: begin
                    // A ready slave beats an expiring budget in the same cycle.
                    if (rdy_ == ENABLE_) begin
                        rd_data_q <= rd_data;
                        cs_q      <= {NUM_CS{DISABLE_}};
                        as_q      <= DISABLE_;
                        ack_q     <= 1'b1;
                        err_q     <= 1'b0;
                        state_q   <= DONE;
                    end else if (timeout_hit) begin
                        rd_data_q <= '0;
                        cs_q      <= {NUM_CS{DISABLE_}};
                        as_q      <= DISABLE_;
                        ack_q     <= 1'b1;
                        err_q     <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                DONE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_q;
    assign err         = err_q;
    assign rd_data_out = rd_data_q;
    assign busy        = busy_q;
    assign cs_         = cs_q;
    assign as_         = as_q;
    assign rw          = rw_q;
    assign addr        = addr_q;
    assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: directed cases from the test plan
// followed by randomized transactions against a timeline-based model.
module tb_bus_master_if;
    import bus_master_pkg::*;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 3;
    localparam int NUM_CS = 8;
    localparam int T      = 16;

    logic              clk;
    logic              reset;
    logic              req;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wr_data;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rd_data_out;
    logic              busy;
    logic [NUM_CS-1:0] cs_;
    logic              as_;
    logic              rw;
    logic [1:0]        addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rdy_;

    bus_master_if #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .SEL_W   (SEL_W),
        .TIMEOUT (T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .ack         (ack),
        .err         (err),
        .rd_data_out (rd_data_out),
        .busy        (busy),
        .cs_         (cs_),
        .as_         (as_),
        .rw          (rw),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .rdy_        (rdy_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Expected DUT outputs for the current cycle
    logic [NUM_CS-1:0] exp_cs;
    logic              exp_as, exp_rw, exp_ack, exp_err, exp_busy;
    logic [1:0]        exp_addr;
    logic [DATA_W-1:0] exp_wd, exp_rd;

    // Observations from the latest transaction, for literal checks
    logic [NUM_CS-1:0] obs_cs;
    logic [1:0]        obs_addr;
    logic              obs_rw, obs_as1, obs_err;
    logic [DATA_W-1:0] obs_wd;
    int                obs_ack_edge, obs_nack, obs_low;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cs_",         64'(cs_),         64'(exp_cs));
            check("as_",         64'(as_),         64'(exp_as));
            check("rw",          64'(rw),          64'(exp_rw));
            check("addr",        64'(addr),        64'(exp_addr));
            check("wr_data",     64'(wr_data),     64'(exp_wd));
            check("ack",         64'(ack),         64'(exp_ack));
            check("err",         64'(err),         64'(exp_err));
            check("rd_data_out", 64'(rd_data_out), 64'(exp_rd));
            check("busy",        64'(busy),        64'(exp_busy));
        end
    end

    task automatic set_reset_exp();
        exp_cs   = '1;
        exp_as   = 1'b1;
        exp_rw   = READ;
        exp_addr = 2'b00;
        exp_wd   = '0;
        exp_ack  = 1'b0;
        exp_err  = 1'b0;
        exp_rd   = '0;
        exp_busy = 1'b0;
    endtask

    // Idle bus cycles: stray rdy_ pulses and junk request fields must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req         = 1'b0;
            req_rw      = 1'($urandom);
            req_addr    = ADDR_W'($urandom);
            req_wr_data = $urandom;
            rdy_        = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            rd_data     = $urandom;
            @(posedge clk); #1;
        end
    endtask

    // One transaction. Edge 1 is the edge that first samples req; the slave
    // presents rdy_=0 for sampling at edges r..r+h-1. The access ends at the
    // first such edge inside [2, T+1], else times out at edge T+1.
    task automatic run_txn(input logic rw_v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wd, input int r, input int h,
                           input logic [DATA_W-1:0] rsp, input bit hold, input int rst_at);
        int e;
        bit to;
        logic [NUM_CS-1:0] cs_exp;
        logic [SEL_W-1:0]  sel;
        e  = T + 1;
        to = 1'b1;
        for (int k = 2; k <= T + 1; k++) begin
            if (k >= r && k <= r + h - 1) begin
                e  = k;
                to = 1'b0;
                break;
            end
        end
        sel    = a[ADDR_W-1 -: SEL_W];
        cs_exp = ~(NUM_CS'(1) << sel);
        obs_ack_edge = 0;
        obs_nack     = 0;
        obs_low      = 0;
        obs_err      = 1'b0;
        for (int k = 1; k <= e + 1; k++) begin
            req = (k <= e) || hold;
            if (k == 1) begin
                req_rw      = rw_v;
                req_addr    = a;
                req_wr_data = wd;
            end else begin
                req_rw      = 1'($urandom);
                req_addr    = ADDR_W'($urandom);
                req_wr_data = $urandom;
            end
            rdy_    = (k >= r && k <= r + h - 1) ? 1'b0 : 1'b1;
            rd_data = (rdy_ == 1'b0) ? rsp : $urandom;
            reset   = (k == rst_at);
            @(posedge clk); #1;
            if (reset) begin
                reset = 1'b0;
                req   = 1'b0;
                rdy_  = 1'b1;
                set_reset_exp();
                return;
            end
            if (k < e) begin
                exp_cs   = cs_exp;
                exp_as   = 1'b0;
                exp_rw   = rw_v;
                exp_addr = a[1:0];
                exp_wd   = wd;
                exp_busy = 1'b1;
                exp_ack  = 1'b0;
                exp_err  = 1'b0;
            end else if (k == e) begin
                exp_cs   = '1;
                exp_as   = 1'b1;
                exp_ack  = 1'b1;
                exp_err  = to;
                exp_rd   = to ? '0 : rsp;
                exp_busy = 1'b1;
            end else begin
                exp_ack  = 1'b0;
                exp_err  = 1'b0;
                exp_busy = 1'b0;
            end
            if (k == 1) begin
                obs_cs   = cs_;
                obs_addr = addr;
                obs_rw   = rw;
                obs_wd   = wr_data;
                obs_as1  = as_;
            end
            if (ack) begin
                obs_nack++;
                if (obs_ack_edge == 0) begin
                    obs_ack_edge = k;
                    obs_err      = err;
                end
            end
            if (as_ == 1'b0) obs_low++;
        end
        $display("[TB] txn rw=%0d addr=0x%08h wd=0x%08h r=%0d h=%0d -> ack@%0d err=%0d rd=0x%08h",
                 rw_v, a, wd, r, h, obs_ack_edge, obs_err, rd_data_out);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] a;
        int r, h, rst_at;
        reset       = 1'b1;
        req         = 1'b0;
        req_rw      = READ;
        req_addr    = '0;
        req_wr_data = '0;
        rd_data     = '0;
        rdy_        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        set_reset_exp();
        chk_en = 1'b1;
        reset  = 1'b0;
        idle(2);

        // Read from the timer, slave registers rdy_ one cycle after as_
        a = {3'(SEL_TIMER), 25'd0, 2'b10};
        run_txn(READ, a, 32'h0, 3, 1, 32'h1234_5678, 1'b0, 0);
        check("timer_cs",      64'(obs_cs),       64'h00FB);
        check("timer_addr",    64'(obs_addr),     64'h2);
        check("timer_ack_edge", 64'(obs_ack_edge), 64'd3);
        check("timer_rd",      64'(rd_data_out),  64'h1234_5678);
        idle(1);

        // Write to select 0, word index 1, slow slave
        a = {3'd0, 25'd0, 2'b01};
        run_txn(WRITE, a, 32'hDEAD_BEEF, 6, 1, 32'h0, 1'b0, 0);
        check("wr_rw",   64'(obs_rw),   64'(WRITE));
        check("wr_cs",   64'(obs_cs),   64'h00FE);
        check("wr_data", 64'(obs_wd),   64'hDEAD_BEEF);
        check("wr_nack", 64'(obs_nack), 64'd1);
        check("wr_err",  64'(obs_err),  64'd0);
        idle(1);

        // No slave answers: strobes low for exactly T cycles then error ack
        run_txn(READ, {3'd5, 27'h12345}, 32'h0, 99, 1, 32'hFFFF_FFFF, 1'b0, 0);
        check("to_low_cycles", 64'(obs_low),      64'd16);
        check("to_ack_edge",   64'(obs_ack_edge), 64'd17);
        check("to_err",        64'(obs_err),      64'd1);
        idle(1);

        // rdy_ lands on the last budget cycle: ready wins
        run_txn(READ, {3'd1, 27'h3}, 32'h0, 17, 1, 32'hCAFE_F00D, 1'b0, 0);
        check("race_ack_edge", 64'(obs_ack_edge), 64'd17);
        check("race_err",      64'(obs_err),      64'd0);
        check("race_rd",       64'(rd_data_out),  64'hCAFE_F00D);
        idle(1);

        // Reset during ACCESS aborts with no ack; next access completes
        run_txn(READ, {3'd3, 27'h7}, 32'h0, 8, 1, 32'h5555_AAAA, 1'b0, 4);
        check("rst_cs",   64'(cs_),  64'h00FF);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ack",  64'(ack),  64'd0);
        idle(1);
        run_txn(READ, {3'd3, 27'h7}, 32'h0, 3, 1, 32'h0BAD_F00D, 1'b0, 0);
        check("post_rst_rd", 64'(rd_data_out), 64'h0BAD_F00D);

        // Back-to-back with req held through ack and a 2-cycle rdy_
        run_txn(READ, {3'd4, 27'h1}, 32'h0, 3, 2, 32'h1111_2222, 1'b1, 0);
        check("b2b_nack1", 64'(obs_nack), 64'd1);
        run_txn(WRITE, {3'd6, 27'h2}, 32'h3333_4444, 3, 2, 32'h7777_8888, 1'b0, 0);
        check("b2b_as",    64'(obs_as1),  64'd0);
        check("b2b_nack2", 64'(obs_nack), 64'd1);
        idle(2);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            r      = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 6);
            h      = $urandom_range(1, 3);
            rst_at = ($urandom_range(0, 19) == 0) ? $urandom_range(2, 18) : 0;
            run_txn(1'($urandom), ADDR_W'($urandom), $urandom, r, h, $urandom,
                    1'($urandom), rst_at);
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
